// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown of results not yet forwardable,
// driving RAW/WAW stalls. Optional stall statistics under HAZARD_STALL_STATS_EN.
module hazard_scoreboard #(
    parameter int NREGS   = 32,
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              flush,
    output logic              stall,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              bubble_idex,
    output logic [NREGS-1:0]  pending
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       waw_stalls
`endif
);

    logic [LAT_W-1:0] w_cnt [NREGS];
    logic [NREGS-1:0] w_pending;
    logic             w_raw_rs;
    logic             w_raw_rt;
    logic             w_waw;
    logic             w_stall;
    logic             w_fire;

    // Register 0 is hardwired zero, so it reads as never pending.
    assign w_cnt[0]     = '0;
    assign w_pending[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [LAT_W-1:0] r_cnt;

            // A new issue reloads the countdown ahead of the decrement.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_fire && issue_wr && (issue_rd == REG_AW'(gi)) && (issue_lat != '0)) begin
                    r_cnt <= issue_lat;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - LAT_W'(1);
                end
            end

            assign w_cnt[gi]     = r_cnt;
            assign w_pending[gi] = (r_cnt != '0);
        end
    endgenerate

    assign w_raw_rs = id_use_rs && (id_rs != '0) && (w_cnt[id_rs] != '0);
    assign w_raw_rt = id_use_rt && (id_rt != '0) && (w_cnt[id_rt] != '0);
    // An older longer-latency write must not land after a younger shorter one.
    assign w_waw    = issue_wr && (issue_rd != '0) && (w_cnt[issue_rd] > issue_lat);

    assign w_stall  = !reset && issue_valid && !flush && (w_raw_rs || w_raw_rt || w_waw);
    assign w_fire   = issue_valid && !w_stall && !flush;

    assign stall       = w_stall;
    assign PCWrite     = !w_stall;
    assign IFID_Write  = !w_stall;
    assign bubble_idex = w_stall || (flush && !reset);
    assign pending     = reset ? '0 : w_pending;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && issue_valid && issue_wr) begin
            assert (issue_lat <= LAT_W'(MAX_LAT));
        end
    end
`endif

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_waw_stalls;

    // Total stall cycles wrap; WAW stall count saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_waw_stalls   <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_stall && w_waw && (r_waw_stalls != 16'hFFFF)) begin
                r_waw_stalls <= r_waw_stalls + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign waw_stalls   = r_waw_stalls;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against a ready-time model of each register.
module tb_hazard_scoreboard;

    localparam int NREGS   = 32;
    localparam int REG_AW  = 5;
    localparam int MAX_LAT = 4;
    localparam int LAT_W   = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_wr = 1'b0;
    logic [REG_AW-1:0] issue_rd = '0;
    logic [LAT_W-1:0]  issue_lat = '0;
    logic [REG_AW-1:0] id_rs = '0;
    logic [REG_AW-1:0] id_rt = '0;
    logic              id_use_rs = 1'b0;
    logic              id_use_rt = 1'b0;
    logic              flush = 1'b0;
    logic              stall;
    logic              PCWrite;
    logic              IFID_Write;
    logic              bubble_idex;
    logic [NREGS-1:0]  pending;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0]       stall_cycles;
    logic [15:0]       waw_stalls;
`endif

    hazard_scoreboard #(
        .NREGS(NREGS), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .flush(flush),
        .stall(stall), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .bubble_idex(bubble_idex), .pending(pending)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(stall_cycles), .waw_stalls(waw_stalls)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: absolute cycle at which each register's result becomes usable.
    longint m_ready [NREGS];
    longint m_now = 0;
    longint m_sc  = 0;
    int     m_ws  = 0;

    logic             s_stall, s_bub, s_pcw, s_ifid;
    logic [NREGS-1:0] s_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int rem(input int r);
        if (r == 0) return 0;
        if (m_ready[r] > m_now) return int'(m_ready[r] - m_now);
        return 0;
    endfunction

    task automatic drive(input bit v, input bit wr, input int rd, input int lat,
                         input int rs, input int rt, input bit urs, input bit urt, input bit fl);
        issue_valid = v;
        issue_wr    = wr;
        issue_rd    = rd[REG_AW-1:0];
        issue_lat   = lat[LAT_W-1:0];
        id_rs       = rs[REG_AW-1:0];
        id_rt       = rt[REG_AW-1:0];
        id_use_rs   = urs;
        id_use_rt   = urt;
        flush       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        bit raw_rs, raw_rt, waw, e_stall, e_bub;
        logic [31:0] e_pend;
        raw_rs = 0; raw_rt = 0; waw = 0; e_stall = 0; e_bub = 0; e_pend = '0;
        @(negedge clock);
        if (!reset) begin
            raw_rs  = id_use_rs && (id_rs != 0) && (rem(int'(id_rs)) > 0);
            raw_rt  = id_use_rt && (id_rt != 0) && (rem(int'(id_rt)) > 0);
            waw     = issue_wr && (issue_rd != 0) && (rem(int'(issue_rd)) > int'(issue_lat));
            e_stall = issue_valid && !flush && (raw_rs || raw_rt || waw);
            e_bub   = e_stall || flush;
            for (int r = 0; r < NREGS; r++) e_pend[r] = (rem(r) > 0);
        end
        s_stall = stall; s_bub = bubble_idex; s_pcw = PCWrite; s_ifid = IFID_Write; s_pend = pending;
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("PCWrite", {31'd0, PCWrite}, {31'd0, !e_stall});
        check("IFID_Write", {31'd0, IFID_Write}, {31'd0, !e_stall});
        check("bubble_idex", {31'd0, bubble_idex}, {31'd0, e_bub});
        check("pending", pending, e_pend);
`ifdef HAZARD_STALL_STATS_EN
        check("stall_cycles", stall_cycles, m_sc[31:0]);
        check("waw_stalls", {16'd0, waw_stalls}, m_ws);
`endif
        @(posedge clock);
        if (reset) begin
            for (int r = 0; r < NREGS; r++) m_ready[r] = 0;
            m_sc = 0;
            m_ws = 0;
        end else begin
            if (issue_valid && !e_stall && !flush && issue_wr && issue_rd != 0 && issue_lat != 0)
                m_ready[issue_rd] = m_now + 1 + longint'(issue_lat);
            if (e_stall) m_sc = (m_sc + 1) % 64'h1_0000_0000;
            if (e_stall && waw && m_ws < 65535) m_ws++;
        end
        m_now++;
        #1;
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) m_ready[r] = 0;

        // Reset, then idle
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_stall", {31'd0, s_stall}, 32'd0);
        check("rst_pending", s_pend, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_stall", {31'd0, s_stall}, 32'd0);
        check("idle_pcw", {31'd0, s_pcw}, 32'd1);
        check("idle_ifid", {31'd0, s_ifid}, 32'd1);
        check("idle_bub", {31'd0, s_bub}, 32'd0);
        check("idle_pending", s_pend, 32'd0);

        // Load-use, lat 1
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0);
        tick();
        check("lu_stall_t1", {31'd0, s_stall}, 32'd1);
        check("lu_bub_t1", {31'd0, s_bub}, 32'd1);
        tick();
        check("lu_stall_t2", {31'd0, s_stall}, 32'd0);

        // Multiply, lat 4, consumer on rt
        drive(1, 1, 7, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mul_stall", {31'd0, s_stall}, 32'd1);
            check("mul_pend7", {31'd0, s_pend[7]}, 32'd1);
        end
        tick();
        check("mul_release", {31'd0, s_stall}, 32'd0);
        check("mul_pend7_clr", {31'd0, s_pend[7]}, 32'd0);

        // WAW: cnt[9]=3 then issue rd=9 lat=1
        drive(1, 1, 9, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
        tick();
        check("waw_stall_a", {31'd0, s_stall}, 32'd1);
        tick();
        check("waw_stall_b", {31'd0, s_stall}, 32'd1);
        tick();
        check("waw_issue", {31'd0, s_stall}, 32'd0);
        idle();
        tick();
        check("waw_reload", {31'd0, s_pend[9]}, 32'd1);
        tick();
        check("waw_done", {31'd0, s_pend[9]}, 32'd0);

        // Register 0 and unused sources
        drive(1, 1, 5, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        check("r0_src", {31'd0, s_stall}, 32'd0);
        drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
        tick();
        check("unused_rs", {31'd0, s_stall}, 32'd0);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        check("rd0_pending", s_pend, 32'd0);

        // Flush with a RAW hazard
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 6, 3, 5, 0, 1, 0, 1);
        tick();
        check("fl_stall", {31'd0, s_stall}, 32'd0);
        check("fl_bub", {31'd0, s_bub}, 32'd1);
        idle();
        tick();
        check("fl_noload", {31'd0, s_pend[6]}, 32'd0);
        check("fl_keep5", {31'd0, s_pend[5]}, 32'd1);
`ifdef HAZARD_STALL_STATS_EN
        check("stats_total", stall_cycles, 32'd7);
        check("stats_waw", {16'd0, waw_stalls}, 32'd2);
`endif

        // Reset mid-countdown
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("rst_mid_pend", s_pend, 32'd0);
        reset = 1'b0;
        tick();
        check("rst_after_pend", s_pend, 32'd0);

        // Random traffic on a small register window to provoke hazards
        repeat (3000) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, MAX_LAT)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
